// File: rtl/ser_rx_if.sv
// ser_rx_if: serial line inputs and received-frame outputs of the link receiver.
//   master : receiver side (samples serial_in/mode, drives frame outputs)
//   slave  : consumer side (drives serial_in/mode, observes frame outputs)
`timescale 1ns/1ps
interface ser_rx_if;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned CRC_W     = 16;

    logic                 serial_in;
    logic                 mode;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [CRC_W-1:0]     rx_crc;
    logic                 frame_valid;
    logic                 crc_err;
    logic                 busy;

    modport master (
        input  serial_in, mode,
        output rx_payload, rx_crc, frame_valid, crc_err, busy
    );

    modport slave (
        output serial_in, mode,
        input  rx_payload, rx_crc, frame_valid, crc_err, busy
    );
endinterface

// File: rtl/ser_rx.sv
// ser_rx: serial frame receiver. Recovers bit timing (sys_clk/32 or /16),
// hunts for a 24-bit sync word, then captures a 32-bit payload and 16-bit CRC.
// Ports:
//   sys_clk  - system clock, rising edge
//   reset    - asynchronous, active-low
//   bus      - ser_rx_if.master: serial_in, mode in; rx_payload, rx_crc,
//              frame_valid (1-cycle pulse), crc_err, busy out
// Optional feature: define SER_RX_CRC_CHECK_EN to build the CRC-16/CCITT
// checker; otherwise crc_err is tied to 0.
`timescale 1ns/1ps
module ser_rx #(
    parameter logic [23:0] SYNC_WORD = 24'h55557A
) (
    input  logic     sys_clk,
    input  logic     reset,
    ser_rx_if.master bus
);
    localparam int unsigned PHASE_W = 5;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WIN_W   = 24;
    localparam int unsigned PAY_W   = 32;
    localparam int unsigned CRC_W   = 16;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] CRC     = 2'd2;

    logic               s1, s2, s3;
    logic               mode_q, mode_prev;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         state, state_next;
    logic [WIN_W-1:0]   window;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PAY_W-1:0]   payload_sr;
    logic [CRC_W-1:0]   crc_sr;
    logic [PAY_W-1:0]   payload_reg;
    logic [CRC_W-1:0]   crc_reg;
    logic               frame_valid_reg;
    logic               busy_reg;

    logic               bit_edge_c, mode_chg_c, strobe_c;
    logic [PHASE_W-1:0] phase_max_c, phase_mid_c;
    logic [WIN_W-1:0]   window_shift_c;
    logic               sync_hit_c, frame_done_c;

    // Input synchronizer, edge detect and mode-change detect
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            mode_q    <= 1'b0;
            mode_prev <= 1'b0;
        end else begin
            s1        <= bus.serial_in;
            s2        <= s1;
            s3        <= s2;
            mode_q    <= bus.mode;
            mode_prev <= mode_q;
        end
    end

    assign bit_edge_c  = s2 ^ s3;
    assign mode_chg_c  = mode_q ^ mode_prev;
    assign phase_max_c = mode_q ? PHASE_W'(15) : PHASE_W'(31);
    assign phase_mid_c = mode_q ? PHASE_W'(7)  : PHASE_W'(15);
    // An edge landing on the mid point only happens before lock; skip it so
    // the freshly changed bit is not sampled twice.
    assign strobe_c    = (phase == phase_mid_c) && !bit_edge_c && !mode_chg_c;

    // Bit-phase counter, realigned on every line transition
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            phase <= '0;
        else if (bit_edge_c || mode_chg_c || phase == phase_max_c)
            phase <= '0;
        else
            phase <= phase + PHASE_W'(1);
    end

    assign window_shift_c = {window[WIN_W-2:0], s2};
    assign sync_hit_c     = (window_shift_c == SYNC_WORD);

    // State register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            state <= HUNT;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next   = state;
        frame_done_c = 1'b0;
        if (mode_chg_c) begin
            state_next = HUNT;
        end else if (strobe_c) begin
            case (state)
                HUNT:    if (sync_hit_c) state_next = PAYLOAD;
                PAYLOAD: if (bit_cnt == CNT_W'(31)) state_next = CRC;
                CRC: begin
                    if (bit_cnt == CNT_W'(15)) begin
                        state_next   = HUNT;
                        frame_done_c = 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Sync window, bit counter and field shift registers
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            window     <= '0;
            bit_cnt    <= '0;
            payload_sr <= '0;
            crc_sr     <= '0;
        end else begin
            if (mode_chg_c || (state != HUNT && state_next == HUNT))
                window <= '0;
            else if (state == HUNT && strobe_c)
                window <= window_shift_c;

            if (mode_chg_c || state_next != state)
                bit_cnt <= '0;
            else if (strobe_c && state != HUNT)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (strobe_c && state == PAYLOAD)
                payload_sr <= {payload_sr[PAY_W-2:0], s2};
            if (strobe_c && state == CRC)
                crc_sr <= {crc_sr[CRC_W-2:0], s2};
        end
    end

    // Output registers, updated only on a completed frame
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            payload_reg     <= '0;
            crc_reg         <= '0;
            frame_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            frame_valid_reg <= frame_done_c;
            busy_reg        <= (state_next != HUNT);
            if (frame_done_c) begin
                payload_reg <= payload_sr;
                crc_reg     <= {crc_sr[CRC_W-2:0], s2};
            end
        end
    end

`ifdef SER_RX_CRC_CHECK_EN
    logic [CRC_W-1:0] crc_calc;
    logic             crc_err_reg;
    logic             crc_fb_c;

    assign crc_fb_c = crc_calc[CRC_W-1] ^ s2;

    // Bit-serial CRC-16/CCITT over the payload, seeded on sync match
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            crc_calc    <= '1;
            crc_err_reg <= 1'b0;
        end else begin
            if (state == HUNT && state_next == PAYLOAD)
                crc_calc <= '1;
            else if (strobe_c && state == PAYLOAD)
                crc_calc <= {crc_calc[CRC_W-2:0], 1'b0} ^ (crc_fb_c ? CRC_W'(16'h1021) : CRC_W'(0));
            if (frame_done_c)
                crc_err_reg <= (crc_calc != {crc_sr[CRC_W-2:0], s2});
        end
    end

    assign bus.crc_err = crc_err_reg;
`else
    assign bus.crc_err = 1'b0;
`endif

    assign bus.rx_payload  = payload_reg;
    assign bus.rx_crc      = crc_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.busy        = busy_reg;
endmodule
